ysyx_23060042_idu: RTL and testbench
====================================

# ysyx_23060042_idu

Instruction decode/issue stage for the NPC core. It accepts one RV32E instruction per handshake and reads the register file. It produces the 3-bit ALU opcode and the two 32-bit ALU operands, plus writeback control, held in a single registered pipeline slot. It sits between the IFU and the EXU and is the sole producer of the ALU's `AluOp`/`data1`/`data2`.

## Interface
- No parameters. Widths are fixed: XLEN 32, register address 4 bits (RV32E).
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `inst_valid`  in  1  IFU presents `inst`/`pc`
- `inst_ready`  out  1  IDU can accept this cycle
- `inst`  in  32  instruction word
- `pc`  in  32  address of `inst`
- `flush`  in  1  discard held slot and any same-cycle input
- `rs1_addr`  out  4  regfile read port 1, combinational from `inst[18:15]`
- `rs2_addr`  out  4  regfile read port 2, combinational from `inst[23:20]`
- `rs1_data`  in  32  combinational read data
- `rs2_data`  in  32  combinational read data
- `ex_valid`  out  1  slot holds a decoded instruction
- `ex_ready`  in  1  EXU consumes the slot this cycle
- `alu_op`  out  3  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 OR, 5 XOR, 6 AND, 7 SLTU
- `alu_data1`  out  32  first operand
- `alu_data2`  out  32  second operand
- `rd_addr`  out  4  destination register
- `rd_wen`  out  1  writeback enable
- `illegal`  out  1  slot holds an unsupported or invalid encoding

## Operation
- Accept condition: `accept = inst_valid && inst_ready && !flush`.
- Ready: `inst_ready = !ex_valid || ex_ready`. This is a pipeline register with no skid buffer.
- Decode rules (imm_i and imm_u are sign-extended / shifted per the RISC-V spec):
  - OP (0110011), funct7 = 0000000: f3 000 ADD, 001 SLL, 101 SRL, 100 XOR, 110 OR, 111 AND, 011 SLTU. Operands are rs1_data, rs2_data.
  - OP, funct7 = 0100000, f3 000: SUB.
  - OP-IMM (0010011): f3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI, 011 SLTIU. Operands are rs1_data, imm_i.
  - OP-IMM SLLI (f3 001) and SRLI (f3 101) are legal only with funct7 = 0. Operand 2 is zero-extended shamt.
  - LUI (0110111): ADD, data1 = 0, data2 = `{inst[31:12], 12'b0}`.
  - AUIPC (0010111): ADD, data1 = `pc`, data2 = imm_u.
- Illegal cases set `illegal = 1`, `alu_op = 0`, `alu_data1 = alu_data2 = 0`, `rd_wen = 0`, `rd_addr = 0`:
  - any other opcode, funct7, or f3;
  - SLT, SLTI, SRA, SRAI;
  - any of rd, rs1, rs2 bit 4 set, checking only the fields the format uses.
- `rd_wen = legal && rd != 0`.
- Slot state machine (EMPTY ↔ FULL, encoded by `ex_valid`):
  - flush: go to EMPTY.
  - EMPTY with accept: load slot, go to FULL.
  - FULL with ex_ready and accept: load the new instruction, stay FULL.
  - FULL with ex_ready and no accept: go to EMPTY.
  - FULL with !ex_ready: hold all outputs stable.
- Payload outputs update only on accept. When EMPTY they keep their last values, and consumers must ignore them.

## Timing
- Latency is 1 cycle: an instruction accepted in cycle N appears with `ex_valid = 1` in cycle N+1.
- Throughput is 1 instruction/cycle while `ex_ready = 1`.
- Operand capture: `rs*_data` is sampled at the accept edge. A later regfile change does not alter a held slot.
- Reset (`rst_n = 0` at an edge) clears `ex_valid`, `alu_op`, `alu_data1`, `alu_data2`, `rd_addr`, `rd_wen` and `illegal` to 0. Reset mid-stall drops the held instruction.
- During reset, `inst_ready` follows `ex_valid`, so it reads 1 after the first reset edge.
- Flush takes priority over accept and over reset-free hold. `inst_ready` is not gated by flush, but no transfer occurs in a flush cycle.
- Backpressure: while `ex_valid && !ex_ready`, `inst_ready = 0` and every output is bit-stable.

## Test plan
- Reset, then `0x00500093` (addi x1,x0,5) with rs1_data = 0 → next cycle: ex_valid 1, alu_op 0, data1 0, data2 5, rd 1, rd_wen 1, illegal 0.
- `0x402081B3` (sub x3,x1,x2) with rs1 = 9, rs2 = 4 → alu_op 1, data1 9, data2 4, rd 3. Hold ex_ready = 0 for 3 cycles → inst_ready 0 and outputs stable. Then ex_ready = 1 → ex_valid drops next cycle if no input.
- `0x123452B7` (lui x5) → data1 0, data2 0x12345000, op 0. Then `0x00001097` (auipc x1,1) at pc 0x80000000 → data1 0x80000000, data2 0x1000.
- `0x4010D093` (srai) → illegal 1, rd_wen 0, op 0. `0x00100813` (addi x16) → illegal 1.
- Back-to-back: 4 instructions with ex_ready held at 1 → 4 consecutive ex_valid cycles in order, inst_ready constantly 1.
- Flush while FULL with an incoming valid instruction → next cycle ex_valid 0, incoming instruction not captured. Reset asserted mid-stall → all outputs 0 after the edge.

Source files
------------

// File: rtl/ysyx_23060042_idu.sv
// RV32E decode/issue stage: decodes one instruction per handshake into ALU opcode,
// operands and writeback control, held in a single registered slot toward the EXU.
module ysyx_23060042_idu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [3:0]  rs1_addr,
  output logic [3:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [3:0]  rd_addr,
  output logic        rd_wen,
  output logic        illegal
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SLL  = 3'd2;
  localparam logic [2:0] OP_SRL  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic        ex_valid_q, ex_valid_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_data1_q, alu_data1_d;
  logic [31:0] alu_data2_q, alu_data2_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        rd_wen_q, rd_wen_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        fmt_ok;
  logic        regs_ok;
  logic        legal;
  logic [2:0]  dec_op;
  logic [31:0] dec_d1;
  logic [31:0] dec_d2;
  logic        accept;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_u    = {inst[31:12], 12'b0};
  assign rs1_addr = inst[18:15];
  assign rs2_addr = inst[23:20];

  assign inst_ready = !ex_valid_q || ex_ready;
  assign accept     = inst_valid && inst_ready && !flush;

  // Register-bit-4 checks cover only the fields each format actually uses.
  always_comb begin
    fmt_ok  = 1'b0;
    regs_ok = 1'b0;
    dec_op  = OP_ADD;
    dec_d1  = rs1_data;
    dec_d2  = rs2_data;
    case (opcode)
      OPC_OP: begin
        regs_ok = !inst[11] && !inst[19] && !inst[24];
        if (funct7 == 7'b0000000) begin
          fmt_ok = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b101:  dec_op = OP_SRL;
            3'b100:  dec_op = OP_XOR;
            3'b110:  dec_op = OP_OR;
            3'b111:  dec_op = OP_AND;
            3'b011:  dec_op = OP_SLTU;
            default: fmt_ok = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          fmt_ok = 1'b1;
          dec_op = OP_SUB;
        end
      end
      OPC_OPIMM: begin
        regs_ok = !inst[11] && !inst[19];
        dec_d2  = imm_i;
        fmt_ok  = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b100:  dec_op = OP_XOR;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b011:  dec_op = OP_SLTU;
          3'b001: begin
            dec_op = OP_SLL;
            dec_d2 = {27'b0, inst[24:20]};
            fmt_ok = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_op = OP_SRL;
            dec_d2 = {27'b0, inst[24:20]};
            fmt_ok = (funct7 == 7'b0000000);
          end
          default: fmt_ok = 1'b0;
        endcase
      end
      OPC_LUI: begin
        regs_ok = !inst[11];
        fmt_ok  = 1'b1;
        dec_d1  = 32'b0;
        dec_d2  = imm_u;
      end
      OPC_AUIPC: begin
        regs_ok = !inst[11];
        fmt_ok  = 1'b1;
        dec_d1  = pc;
        dec_d2  = imm_u;
      end
      default: fmt_ok = 1'b0;
    endcase
    legal = fmt_ok && regs_ok;
  end

  // Slot control: flush beats accept; payload changes only when a new instruction lands.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    alu_op_d    = alu_op_q;
    alu_data1_d = alu_data1_q;
    alu_data2_d = alu_data2_q;
    rd_addr_d   = rd_addr_q;
    rd_wen_d    = rd_wen_q;
    illegal_d   = illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      if (legal) begin
        alu_op_d    = dec_op;
        alu_data1_d = dec_d1;
        alu_data2_d = dec_d2;
        rd_addr_d   = inst[10:7];
        rd_wen_d    = (inst[10:7] != 4'd0);
        illegal_d   = 1'b0;
      end else begin
        alu_op_d    = OP_ADD;
        alu_data1_d = 32'b0;
        alu_data2_d = 32'b0;
        rd_addr_d   = 4'd0;
        rd_wen_d    = 1'b0;
        illegal_d   = 1'b1;
      end
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      alu_op_q    <= 3'd0;
      alu_data1_q <= 32'b0;
      alu_data2_q <= 32'b0;
      rd_addr_q   <= 4'd0;
      rd_wen_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      alu_op_q    <= alu_op_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
      rd_addr_q   <= rd_addr_d;
      rd_wen_q    <= rd_wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_data1 = alu_data1_q;
  assign alu_data2 = alu_data2_q;
  assign rd_addr   = rd_addr_q;
  assign rd_wen    = rd_wen_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ysyx_23060042_idu.sv
// Scoreboard bench for the IDU: the driver pushes hand-computed expectations on accept,
// a negedge monitor pops and compares whenever the EXU consumes the slot.
module tb_ysyx_23060042_idu;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        flush;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  alu_op;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [3:0]  rd_addr;
  logic        rd_wen;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   m_valid;

  ysyx_23060042_idu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc         (pc),
    .flush      (flush),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .alu_op     (alu_op),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .rd_addr    (rd_addr),
    .rd_wen     (rd_wen),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [3:0] rd, input logic wen, input logic ill);
    exp_t e;
    e.op = op; e.d1 = d1; e.d2 = d2; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  task automatic chk_slot(input string tag, input exp_t e);
    chk({tag, ".alu_op"},    {29'b0, alu_op}, {29'b0, e.op});
    chk({tag, ".alu_data1"}, alu_data1, e.d1);
    chk({tag, ".alu_data2"}, alu_data2, e.d2);
    chk({tag, ".rd_addr"},   {28'b0, rd_addr}, {28'b0, e.rd});
    chk({tag, ".rd_wen"},    {31'b0, rd_wen}, {31'b0, e.wen});
    chk({tag, ".illegal"},   {31'b0, illegal}, {31'b0, e.ill});
  endtask

  // Monitor: the slot is consumed at the next rising edge when ex_valid && ex_ready.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ex: got ex_valid 1 expected no pending instruction");
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("consume op=%0d d1=0x%08h d2=0x%08h rd=%0d wen=%0d ill=%0d",
                 alu_op, alu_data1, alu_data2, rd_addr, rd_wen, illegal);
        chk_slot("slot", e);
      end
    end
  end

  // One cycle of stimulus, starting just after a rising edge.
  task automatic cyc(input bit v, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input bit er, input bit fl, input exp_t e);
    bit acc;
    inst_valid = v; inst = i; pc = p; rs1_data = r1; rs2_data = r2;
    ex_ready = er; flush = fl;
    acc = v && (!m_valid || er) && !fl;
    #1;
    chk("inst_ready", {31'b0, inst_ready}, {31'b0, (!m_valid || er)});
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else if (acc) begin
      q.push_back(e);
      m_valid = 1'b1;
    end else if (er) begin
      m_valid = 1'b0;
    end
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
  endtask

  exp_t NONE, E_ADDI, E_SUB, E_LUI, E_AUIPC, E_ILL;
  exp_t E_ADD, E_XORI, E_SLLI, E_SLTU;

  initial begin
    NONE    = mk(3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    E_ADDI  = mk(3'd0, 32'd0, 32'd5, 4'd1, 1'b1, 1'b0);
    E_SUB   = mk(3'd1, 32'd9, 32'd4, 4'd3, 1'b1, 1'b0);
    E_LUI   = mk(3'd0, 32'd0, 32'h12345000, 4'd5, 1'b1, 1'b0);
    E_AUIPC = mk(3'd0, 32'h80000000, 32'h00001000, 4'd1, 1'b1, 1'b0);
    E_ILL   = mk(3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    E_ADD   = mk(3'd0, 32'd7, 32'd8, 4'd3, 1'b1, 1'b0);
    E_XORI  = mk(3'd5, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'd4, 1'b1, 1'b0);
    E_SLLI  = mk(3'd2, 32'h11, 32'd3, 4'd5, 1'b1, 1'b0);
    E_SLTU  = mk(3'd7, 32'd1, 32'd2, 4'd0, 1'b0, 1'b0);

    rst_n = 1'b0; inst_valid = 1'b0; inst = 32'd0; pc = 32'd0; flush = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; ex_ready = 1'b0; m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset.inst_ready", {31'b0, inst_ready}, 32'd1);
    chk_slot("reset", NONE);
    rst_n = 1'b1;

    cyc(1, 32'h00500093, 32'd0, 32'd0, 32'd0, 1, 0, E_ADDI);
    cyc(1, 32'h402081B3, 32'd0, 32'd9, 32'd4, 1, 0, E_SUB);
    // Stall: offered lui must not be taken, and a changed regfile must not leak in.
    repeat (3) begin
      cyc(1, 32'h123452B7, 32'd0, 32'h55, 32'h66, 0, 0, NONE);
      chk_slot("stall", E_SUB);
    end
    cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, NONE);

    cyc(1, 32'h123452B7, 32'd0, 32'd0, 32'd0, 1, 0, E_LUI);
    cyc(1, 32'h00001097, 32'h80000000, 32'd0, 32'd0, 1, 0, E_AUIPC);
    cyc(1, 32'h4010D093, 32'd0, 32'd3, 32'd0, 1, 0, E_ILL);
    cyc(1, 32'h00100813, 32'd0, 32'd0, 32'd0, 1, 0, E_ILL);

    cyc(1, 32'h002081B3, 32'd0, 32'd7, 32'd8, 1, 0, E_ADD);
    cyc(1, 32'hFFF14213, 32'd0, 32'h0F0F0F0F, 32'd0, 1, 0, E_XORI);
    cyc(1, 32'h00309293, 32'd0, 32'h11, 32'd0, 1, 0, E_SLLI);
    cyc(1, 32'h0020B033, 32'd0, 32'd1, 32'd2, 1, 0, E_SLTU);
    cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, NONE);

    cyc(1, 32'h00500093, 32'd0, 32'd0, 32'd0, 1, 0, E_ADDI);
    cyc(1, 32'h123452B7, 32'd0, 32'd0, 32'd0, 0, 1, NONE);
    cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, NONE);

    cyc(1, 32'h402081B3, 32'd0, 32'd9, 32'd4, 1, 0, E_SUB);
    cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, NONE);
    rst_n = 1'b0;
    ex_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_stall.ex_valid", {31'b0, ex_valid}, 32'd0);
    chk_slot("rst_stall", NONE);
    q.delete();
    m_valid = 1'b0;
    rst_n = 1'b1;

    cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, NONE);
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
